// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the PC sequencer / fetch front end
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  // Branch targets are word-aligned; low bits are dropped, not faulted.
  function automatic logic [31:0] align_target(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_seq_if.sv
// rtl/pc_fetch_seq_if.sv - instruction memory request/ack and downstream valid/ready bundle
interface pc_fetch_seq_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [31:0]       imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [31:0]       inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_timer.sv
// rtl/fetch_timer.sv - request timeout counter with sticky fetch_err
module fetch_timer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic fetch_err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Counter saturates at LIMIT so a long stall cannot wrap it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      fetch_err <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != LIMIT) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) fetch_err <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_seq.sv
// rtl/pc_fetch_seq.sv - PC register, fetch FSM and instruction hand-off to downstream
module pc_fetch_seq
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [31:0]          redirect_addr,
  pc_fetch_seq_if.master       bus,
  output logic                 fetch_err,
  output logic                 align_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         kill;
  logic [31:0]  target;
  logic         fetch_start;
  logic         timer_clr;
  logic         timer_inc;

  assign target = align_target(redirect_addr);

  // A new request launches from IDLE, or from HOLD in the same cycle the word is consumed.
  assign fetch_start = !redirect && !stall &&
                       ((state == ST_IDLE) || (state == ST_HOLD && bus.inst_ready));
  assign timer_clr   = fetch_start || (state == ST_FETCH && bus.imem_ack);
  assign timer_inc   = (state == ST_FETCH) && !bus.imem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      kill           <= 1'b0;
      bus.imem_req   <= 1'b0;
      bus.imem_addr  <= RESET_PC;
      bus.inst_valid <= 1'b0;
      bus.inst       <= '0;
      bus.inst_pc    <= '0;
      align_err      <= 1'b0;
    end else begin
      if (redirect && redirect_addr[1:0] != 2'b00) align_err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            pc <= target;
          end else if (!stall) begin
            bus.imem_addr <= pc;
            bus.imem_req  <= 1'b1;
            state         <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            bus.imem_req <= 1'b0;
            if (!kill && !redirect) begin
              bus.inst       <= bus.imem_rdata;
              bus.inst_pc    <= bus.imem_addr;
              bus.inst_valid <= 1'b1;
              pc             <= bus.imem_addr + PC_STEP;
              state          <= ST_HOLD;
            end else begin
              kill  <= 1'b0;
              if (redirect) pc <= target;
              state <= ST_IDLE;
            end
          end else if (redirect) begin
            // Address must stay stable while req is up, so squash the reply instead.
            pc   <= target;
            kill <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (bus.inst_ready || redirect) begin
            bus.inst_valid <= 1'b0;
            if (redirect) pc <= target;
            if (fetch_start) begin
              bus.imem_addr <= pc;
              bus.imem_req  <= 1'b1;
              state         <= ST_FETCH;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clr       (timer_clr),
    .inc       (timer_inc),
    .fetch_err (fetch_err)
  );

endmodule

// File: tb/tb_pc_fetch_seq.sv
// tb/tb_pc_fetch_seq.sv - directed self-checking bench for pc_fetch_seq
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        fetch_err;
  logic        align_err;

  int tests_run = 0;
  int tests_failed = 0;

  pc_fetch_seq_if bus ();

  pc_fetch_seq #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (16),
    .CNT_W    (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .bus           (bus),
    .fetch_err     (fetch_err),
    .align_err     (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},   {31'd0, bus.imem_req},   32'd0);
    check({tag, " addr"},  bus.imem_addr,           32'd0);
    check({tag, " valid"}, {31'd0, bus.inst_valid}, 32'd0);
    check({tag, " inst"},  bus.inst,                32'd0);
    check({tag, " ipc"},   bus.inst_pc,             32'd0);
    check({tag, " ferr"},  {31'd0, fetch_err},      32'd0);
    check({tag, " aerr"},  {31'd0, align_err},      32'd0);
  endtask

  // Request should be up at addr; ack it with data and expect the word delivered next cycle.
  task automatic fetch_ack(input string tag, input logic [31:0] addr, input logic [31:0] data);
    check({tag, " req"},  {31'd0, bus.imem_req}, 32'd1);
    check({tag, " addr"}, bus.imem_addr,         addr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = data;
    step();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    check({tag, " valid"}, {31'd0, bus.inst_valid}, 32'd1);
    check({tag, " inst"},  bus.inst,                data);
    check({tag, " ipc"},   bus.inst_pc,             addr);
    check({tag, " req_lo"}, {31'd0, bus.imem_req},  32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirect_addr  = 32'd0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.inst_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;

    // 1: sequential fetch 0,4,8 with ack the cycle after req
    step();
    fetch_ack("seq0", 32'h0, 32'hA000_0000);
    bus.inst_ready = 1'b1;
    step();
    check("seq0 consumed", {31'd0, bus.inst_valid}, 32'd0);
    fetch_ack("seq1", 32'h4, 32'hA000_0001);
    step();
    fetch_ack("seq2", 32'h8, 32'hA000_0002);

    // 2: held instruction stays put while downstream is not ready
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold valid", {31'd0, bus.inst_valid}, 32'd1);
      check("hold inst",  bus.inst,                32'hA000_0002);
      check("hold ipc",   bus.inst_pc,             32'h8);
      check("hold req",   {31'd0, bus.imem_req},   32'd0);
    end
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("after hold req",  {31'd0, bus.imem_req}, 32'd1);
    check("after hold addr", bus.imem_addr,         32'hC);

    // 3: redirect while fetch of 0xC is outstanding; late ack is discarded
    step();
    redirect = 1'b1; redirect_addr = 32'h40;
    step();
    redirect = 1'b0;
    check("kill addr stable", bus.imem_addr,         32'hC);
    check("kill req",         {31'd0, bus.imem_req}, 32'd1);
    step();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
    step();
    bus.imem_ack = 1'b0;
    check("kill no valid", {31'd0, bus.inst_valid}, 32'd0);
    check("kill req lo",   {31'd0, bus.imem_req},   32'd0);
    step();
    check("kill no valid2", {31'd0, bus.inst_valid}, 32'd0);
    fetch_ack("redir40", 32'h40, 32'hB000_0040);

    // 4: branch consumed with redirect in the same cycle
    bus.inst_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'h100;
    step();
    bus.inst_ready = 1'b0; redirect = 1'b0;
    check("br valid lo", {31'd0, bus.inst_valid}, 32'd0);
    check("br req lo",   {31'd0, bus.imem_req},   32'd0);
    step();
    fetch_ack("br100", 32'h100, 32'hB000_0100);

    // 5: misaligned redirect drops the held word; stall keeps IDLE
    redirect = 1'b1; redirect_addr = 32'h203;
    step();
    redirect = 1'b0; stall = 1'b1;
    check("align err",   {31'd0, align_err},      32'd1);
    check("drop valid",  {31'd0, bus.inst_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall req", {31'd0, bus.imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    fetch_ack("align200", 32'h200, 32'hC000_0200);
    check("align sticky", {31'd0, align_err}, 32'd1);

    // PC wrap at the top of the address space
    bus.inst_ready = 1'b1; redirect = 1'b1; redirect_addr = 32'hFFFF_FFFC;
    step();
    bus.inst_ready = 1'b0; redirect = 1'b0;
    step();
    fetch_ack("top", 32'hFFFF_FFFC, 32'hD000_0000);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    check("wrap req",  {31'd0, bus.imem_req}, 32'd1);
    check("wrap addr", bus.imem_addr,         32'h0);
    check("wrap ferr", {31'd0, fetch_err},    32'd0);

    // 6: timeout with ack withheld, then async reset mid-wait
    for (int i = 1; i <= 15; i++) begin
      step();
      check("to pre ferr", {31'd0, fetch_err}, 32'd0);
      check("to addr",     bus.imem_addr,      32'h0);
    end
    step();
    check("to ferr 16", {31'd0, fetch_err},    32'd1);
    check("to req",     {31'd0, bus.imem_req}, 32'd1);
    step();
    step();
    check("to ferr sticky", {31'd0, fetch_err}, 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst mid");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
